// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8-bit UART transmitter with start/stop framing and an optional even-parity bit.
// Ports: clk, rst (async, active-high); tx_start/data_in request a frame in IDLE;
// tx is the serial line; tx_busy marks a frame in flight; tx_done pulses once after the stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and stop (8E1 instead of 8N1).
module uart_tx_ctrl #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  if (DIV < 2) begin : g_div_check
    $error("uart_tx_ctrl: CLK_FREQ/BAUD_RATE must be at least 2");
  end
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] dq, dq_n;
  logic tx_n, busy_n, done_n;
  logic wrap;
  assign wrap = cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      dq      <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      dq      <= dq_n;
      tx      <= tx_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  // Outputs are computed one cycle ahead so the line level changes on the same edge as the state.
  always_comb begin
    state_n = state;
    cnt_n   = wrap ? '0 : cnt + 1'b1;
    idx_n   = idx;
    dq_n    = dq;
    tx_n    = tx;
    busy_n  = tx_busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (tx_start) begin
          state_n = START;
          dq_n    = data_in;
          idx_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START:
        if (wrap) begin
          state_n = DATA;
          tx_n    = dq[0];
        end
      DATA:
        if (wrap) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = ^dq;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = dq[idx + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (wrap) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
`endif
      STOP:
        if (wrap) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl at DIV=10.
module tb_uart_tx_ctrl;
  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * DIV;
  localparam int MAXN = 2 * FL + 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic tx, tx_busy, tx_done;
  int checks = 0;
  int errors = 0;
  logic obs_tx [MAXN];
  logic obs_busy [MAXN];
  logic obs_done [MAXN];
  uart_tx_ctrl #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .data_in(data_in),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (NB == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction
  // Requests a frame with byte d, then records n samples starting the cycle after the accepting edge.
  task automatic scan(input logic [7:0] d, input bit keep, input int set_at, input logic [7:0] set_d,
                      input int clr_at, input int n);
    tx_start = 1'b1;
    data_in = d;
    @(posedge clk); #1;
    if (!keep) tx_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      obs_tx[k] = tx;
      obs_busy[k] = tx_busy;
      obs_done[k] = tx_done;
      if (k == set_at) begin tx_start = 1'b1; data_in = set_d; end
      if (k == clr_at) begin tx_start = 1'b0; data_in = ~data_in; end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
    rst = 1'b0;
    tx_start = 1'b1;
    data_in = 8'hC3;
    @(posedge clk); #1;
    tx_start = 1'b0;
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL first_accept_busy got %b want 1", tx_busy); end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL first_accept_tx got %b want 0", tx); end
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_rst_tx got %b want 1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", tx_busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 2 * DIV; k++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle k=%0d tx/busy/done got %b%b%b want 100", k, tx, tx_busy, tx_done);
      end
    end
  endtask
  task automatic test_single_frame();
    int busy_cnt, done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    scan(8'hA5, 1'b0, -1, 8'h00, -1, FL + 2);
    for (int k = 0; k < FL; k++) begin
      checks++;
      if (obs_tx[k] !== exp_bit(8'hA5, k / DIV)) begin
        errors++;
        $display("FAIL frame_a5 k=%0d tx got %b want %b", k, obs_tx[k], exp_bit(8'hA5, k / DIV));
      end
    end
    for (int k = 0; k < FL + 2; k++) begin
      busy_cnt += int'(obs_busy[k] === 1'b1);
      done_cnt += int'(obs_done[k] === 1'b1);
    end
    checks++; if (busy_cnt != FL) begin errors++; $display("FAIL busy_len got %0d want %0d", busy_cnt, FL); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_pulses got %0d want 1", done_cnt); end
    checks++; if (obs_done[FL] !== 1'b1) begin errors++; $display("FAIL done_pos got %b want 1", obs_done[FL]); end
    checks++; if (obs_busy[FL] !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b want 0", obs_busy[FL]); end
    checks++; if (obs_tx[FL] !== 1'b1) begin errors++; $display("FAIL idle_after got %b want 1", obs_tx[FL]); end
  endtask
  task automatic test_ignore_busy();
    scan(8'h00, 1'b0, 30, 8'hFF, 31, FL + 4);
    for (int k = 0; k < FL; k++) begin
      checks++;
      if (obs_tx[k] !== exp_bit(8'h00, k / DIV) || obs_busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL ignore_frame k=%0d tx/busy got %b%b want %b1", k, obs_tx[k], obs_busy[k], exp_bit(8'h00, k / DIV));
      end
    end
    for (int k = FL; k < FL + 4; k++) begin
      checks++;
      if (obs_tx[k] !== 1'b1 || obs_busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL ignore_noqueue k=%0d tx/busy got %b%b want 10", k, obs_tx[k], obs_busy[k]);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic e;
    scan(8'h55, 1'b1, -1, 8'h00, FL + 1, 2 * FL + 3);
    for (int k = 0; k < 2 * FL + 3; k++) begin
      e = (k < FL) ? exp_bit(8'h55, k / DIV) :
          (k == FL) ? 1'b1 :
          (k < 2 * FL + 1) ? exp_bit(8'h55, (k - FL - 1) / DIV) : 1'b1;
      checks++;
      if (obs_tx[k] !== e) begin
        errors++;
        $display("FAIL b2b_tx k=%0d got %b want %b", k, obs_tx[k], e);
      end
    end
    checks++; if (obs_done[FL] !== 1'b1 || obs_busy[FL] !== 1'b0) begin
      errors++; $display("FAIL b2b_gap done/busy got %b%b want 10", obs_done[FL], obs_busy[FL]); end
    checks++; if (obs_busy[FL + 1] !== 1'b1) begin
      errors++; $display("FAIL b2b_restart busy got %b want 1", obs_busy[FL + 1]); end
    checks++; if (obs_done[2 * FL + 1] !== 1'b1) begin
      errors++; $display("FAIL b2b_done2 got %b want 1", obs_done[2 * FL + 1]); end
    checks++; if (obs_busy[2 * FL + 2] !== 1'b0) begin
      errors++; $display("FAIL b2b_stop busy got %b want 0", obs_busy[2 * FL + 2]); end
  endtask
  task automatic test_handshake();
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL hs_pre_busy got %b want 0", tx_busy); end
    scan(8'h3C, 1'b0, -1, 8'h00, -1, FL + 1);
    checks++; if (obs_busy[0] !== 1'b1) begin errors++; $display("FAIL hs_busy got %b want 1", obs_busy[0]); end
    checks++; if (obs_tx[0] !== 1'b0) begin errors++; $display("FAIL hs_start_bit got %b want 0", obs_tx[0]); end
    checks++; if (obs_busy[FL - 1] !== 1'b1) begin errors++; $display("FAIL hs_last_busy got %b want 1", obs_busy[FL - 1]); end
  endtask
`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int busy_cnt;
    busy_cnt = 0;
    scan(8'h07, 1'b0, -1, 8'h00, -1, FL + 2);
    for (int k = 0; k < FL + 2; k++) busy_cnt += int'(obs_busy[k] === 1'b1);
    checks++; if (obs_tx[9 * DIV + 5] !== 1'b1) begin errors++; $display("FAIL parity_07 got %b want 1", obs_tx[9 * DIV + 5]); end
    checks++; if (busy_cnt != 110) begin errors++; $display("FAIL parity_len got %0d want 110", busy_cnt); end
    scan(8'hA5, 1'b0, -1, 8'h00, -1, FL + 2);
    checks++; if (obs_tx[9 * DIV + 5] !== 1'b0) begin errors++; $display("FAIL parity_a5 got %b want 0", obs_tx[9 * DIV + 5]); end
    checks++; if (obs_done[110] !== 1'b1) begin errors++; $display("FAIL parity_done got %b want 1", obs_done[110]); end
  endtask
`endif
  initial begin
    test_reset();
    test_single_frame();
    test_ignore_busy();
    test_back_to_back();
    test_handshake();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
